// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and default widths
// for the immediate decode pipeline.
package imm_pkg;

  localparam int XLEN_DEF = 32;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] FMT_I     = 3'd0;
  localparam logic [SEL_W-1:0] FMT_S     = 3'd1;
  localparam logic [SEL_W-1:0] FMT_B     = 3'd2;
  localparam logic [SEL_W-1:0] FMT_U     = 3'd3;
  localparam logic [SEL_W-1:0] FMT_J     = 3'd4;
  localparam logic [SEL_W-1:0] FMT_ZIMM  = 3'd5;
  localparam logic [SEL_W-1:0] FMT_SHAMT = 3'd6;

endpackage

// File: rtl/imm_format_extend.sv
// Combinational immediate extraction and extension
// from a raw 32-bit instruction word.
module imm_format_extend
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int SEL_W = imm_pkg::SEL_W
) (
  input  logic [31:0]      instr,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  logic [31:0] raw;
  logic        sx;
  logic        s;
  logic        unused_opc;

  assign s          = instr[31];
  assign unused_opc = ^instr[6:0];

  always_comb begin
    raw     = '0;
    sx      = 1'b0;
    illegal = 1'b0;
    unique case (sel)
      FMT_I: begin
        raw = {{20{s}}, instr[31:20]};
        sx  = 1'b1;
      end
      FMT_S: begin
        raw = {{20{s}}, instr[31:25], instr[11:7]};
        sx  = 1'b1;
      end
      FMT_B: begin
        raw = {{19{s}}, s, instr[7],
               instr[30:25], instr[11:8], 1'b0};
        sx  = 1'b1;
      end
      FMT_U: begin
        raw = {instr[31:12], 12'b0};
        sx  = 1'b1;
      end
      FMT_J: begin
        raw = {{11{s}}, s, instr[19:12],
               instr[20], instr[30:21], 1'b0};
        sx  = 1'b1;
      end
      FMT_ZIMM:
        raw = {27'b0, instr[19:15]};
      FMT_SHAMT:
        // RV64 shifts use a 6-bit shamt
        raw = (XLEN == 32) ? {27'b0, instr[24:20]}
                           : {26'b0, instr[25:20]};
      default:
        illegal = 1'b1;
    endcase
  end

  assign imm = sx ? XLEN'($signed(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decode stage: extension in front of a
// 2-entry skid buffer with valid/ready handshakes.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 32,
  parameter int SEL_W = imm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  ext_imm;
  logic             ext_ill;

  logic             main_v;
  logic             skid_v;
  logic             rdy_q;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;

  logic             acc;
  logic             drain;
  logic             main_v_n;
  logic             skid_v_n;
  logic             ld_in;
  logic             ld_sm;
  logic             ld_skid;

  imm_format_extend #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_ext (
    .instr   (in_instr),
    .sel     (in_sel),
    .imm     (ext_imm),
    .illegal (ext_ill)
  );

  assign acc       = in_valid & rdy_q;
  assign drain     = main_v & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = main_v;

  always_comb begin
    main_v_n = main_v;
    skid_v_n = skid_v;
    ld_in    = 1'b0;
    ld_sm    = 1'b0;
    ld_skid  = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (skid_v) begin
      // in_ready is low here, so only a drain can happen
      if (drain) begin
        ld_sm    = 1'b1;
        skid_v_n = 1'b0;
      end
    end else if (!main_v || drain) begin
      main_v_n = acc;
      ld_in    = acc;
    end else if (acc) begin
      ld_skid  = 1'b1;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v      <= 1'b0;
      skid_v      <= 1'b0;
      rdy_q       <= 1'b0;
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      skid_imm    <= '0;
      skid_tag    <= '0;
      skid_ill    <= 1'b0;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
      if (ld_in) begin
        out_imm     <= ext_imm;
        out_tag     <= in_tag;
        out_illegal <= ext_ill;
      end else if (ld_sm) begin
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_ill;
      end
      if (ld_skid) begin
        skid_imm <= ext_imm;
        skid_tag <= in_tag;
        skid_ill <= ext_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: extension
// formats, skid buffering, flush and async reset.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_imm;
  logic [31:0] out_tag;
  logic        out_illegal;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic        out_illegal64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_sel      (in_sel),
    .in_tag      (in_tag),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  imm_decode_pipe #(.XLEN(64)) dut64 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .in_instr    (in_instr),
    .in_sel      (in_sel),
    .in_tag      (in_tag),
    .flush       (flush),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .out_imm     (out_imm64),
    .out_tag     (out_tag64),
    .out_illegal (out_illegal64)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s,
                       input logic [31:0] ins,
                       input logic [31:0] t);
    in_valid = 1'b1;
    in_sel   = s;
    in_instr = ins;
    in_tag   = t;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_sel    = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_illegal", out_illegal, 0);
    #3 rst_n = 1'b1;
    tick;
    check("ready_after_rst", in_ready, 1);
    check("ready_after_rst64", in_ready64, 1);

    drive(3'd0, 32'hFFF00093, 32'd10);
    tick;
    check("i_valid", out_valid, 1);
    check("i_imm", out_imm, 64'hFFFFFFFF);
    check("i_ill", out_illegal, 0);
    check("i_tag", out_tag, 10);
    check("i_imm64", out_imm64, 64'hFFFFFFFF_FFFFFFFF);

    drive(3'd1, 32'hFE000FA3, 32'd11);
    tick;
    check("s_imm", out_imm, 64'hFFFFFFFF);

    drive(3'd2, 32'hFE000EE3, 32'd12);
    tick;
    check("b_imm", out_imm, 64'hFFFFFFFC);
    check("b_tag", out_tag, 12);

    drive(3'd3, 32'h123450B7, 32'd13);
    tick;
    check("u_imm", out_imm, 64'h12345000);
    check("u_imm64", out_imm64, 64'h12345000);

    drive(3'd4, 32'h8000006F, 32'd14);
    tick;
    check("j_imm", out_imm, 64'hFFF00000);

    drive(3'd5, 32'h000F8073, 32'd15);
    tick;
    check("zimm_imm", out_imm, 64'h1F);

    drive(3'd6, 32'h03F01013, 32'd16);
    tick;
    check("shamt_imm32", out_imm, 64'h1F);
    check("shamt_imm64", out_imm64, 64'h3F);

    drive(3'd7, 32'hFFFFFFFF, 32'd17);
    tick;
    check("bad_imm", out_imm, 0);
    check("bad_ill", out_illegal, 1);
    check("bad_imm64", out_imm64, 0);

    in_valid = 1'b0;
    tick;
    check("drain_valid", out_valid, 0);

    out_ready = 1'b0;
    drive(3'd0, 32'h00100093, 32'd1);
    tick;
    check("skid_t1_tag", out_tag, 1);
    check("skid_t1_rdy", in_ready, 1);
    drive(3'd0, 32'h00200093, 32'd2);
    tick;
    check("skid_t2_rdy", in_ready, 0);
    check("skid_t2_hold", out_tag, 1);
    drive(3'd0, 32'h00300093, 32'd3);
    tick;
    check("skid_t3_rdy", in_ready, 0);
    check("skid_t3_hold", out_tag, 1);
    check("skid_t3_imm", out_imm, 1);
    out_ready = 1'b1;
    tick;
    check("order2_valid", out_valid, 1);
    check("order2_tag", out_tag, 2);
    check("order2_imm", out_imm, 2);
    check("order2_rdy", in_ready, 1);
    tick;
    in_valid = 1'b0;
    check("order3_valid", out_valid, 1);
    check("order3_tag", out_tag, 3);
    tick;
    check("order_empty", out_valid, 0);

    out_ready = 1'b0;
    drive(3'd0, 32'h00400093, 32'd4);
    tick;
    drive(3'd0, 32'h00500093, 32'd5);
    tick;
    check("fl_full_rdy", in_ready, 0);
    drive(3'd0, 32'h00600093, 32'd6);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_rdy", in_ready, 1);
    out_ready = 1'b1;
    tick;
    check("fl_no_ghost", out_valid, 0);

    out_ready = 1'b0;
    drive(3'd0, 32'h00700093, 32'd7);
    tick;
    drive(3'd0, 32'h00800093, 32'd8);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl1_valid", out_valid, 0);
    check("fl1_rdy", in_ready, 1);
    out_ready = 1'b1;
    drive(3'd0, 32'h00900093, 32'd9);
    tick;
    in_valid = 1'b0;
    check("fl1_next_tag", out_tag, 9);
    check("fl1_next_imm", out_imm, 9);
    tick;

    out_ready = 1'b0;
    drive(3'd0, 32'h00A00093, 32'd20);
    tick;
    drive(3'd0, 32'h00B00093, 32'd21);
    tick;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_rdy", in_ready, 0);
    check("arst_tag", out_tag, 0);
    #2 rst_n = 1'b1;
    tick;
    check("arst_rel_rdy", in_ready, 1);
    check("arst_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(3'd3, 32'hABCDE0B7, 32'd22);
    tick;
    in_valid = 1'b0;
    check("arst_new_valid", out_valid, 1);
    check("arst_new_tag", out_tag, 22);
    check("arst_new_imm", out_imm, 64'hABCDE000);
    check("arst_new_imm64", out_imm64,
          64'hFFFFFFFF_ABCDE000);
    tick;
    check("arst_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
